mem_dp_be: RTL and testbench

Simple-dual-port synchronous memory. It generalises the team's single-port 1K x 32 read/write store.
- Separate write and read ports, both usable in the same cycle.
- Per-byte write enables.
- Configurable read latency and read-during-write policy.
- Optional hardware clear sequencer that zeroes the whole array after reset.
- Serves as the shared buffer RAM under the bus-facing register and DMA blocks.

---
 rtl/mem_dp_be.sv | 148 ++++++++++++++
 tb/tb_mem_dp_be.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dp_be.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle registered reads,
// selectable read-during-write policy and an optional post-reset clear sequencer.
module mem_dp_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int RD_LATENCY     = 1,
   parameter int WR_FIRST       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    drop_err
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("mem_dp_be: DATA_WIDTH must be a positive multiple of 8");
   end
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("mem_dp_be: RD_LATENCY must be 1 or 2");
   end

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    clearWr;
   logic                    wrAccept, rdAccept;
   logic [DATA_WIDTH-1:0]   rdWord;
   logic [DATA_WIDTH-1:0]   rdData_q, rdData_d;
   logic                    rdValid_q, rdValid_d;
   logic                    dropErr_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clearWr = 1'b0;
      case (state_q)
         CLEAR: begin
            clearWr = 1'b1;
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = READY;
            end
         end
         default: state_d = READY;
      endcase
   end

   assign busy     = (state_q == CLEAR);
   assign wrAccept = wr_en && !busy && !rst;
   assign rdAccept = rd_en && !busy;

   // The array has no reset; rst only gates writes so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (clearWr && !rst) begin
         mem_q[cnt_q] <= '0;
      end else if (wrAccept) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Write-first collision merges the incoming bytes over the stored word.
   always_comb begin
      rdWord = mem_q[rd_addr];
      if (WR_FIRST != 0 && wrAccept && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               rdWord[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] stageData_q;
      logic                  stageValid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stageData_q  <= '0;
            stageValid_q <= 1'b0;
         end else begin
            stageValid_q <= rdAccept;
            if (rdAccept) begin
               stageData_q <= rdWord;
            end
         end
      end

      assign rdData_d  = stageData_q;
      assign rdValid_d = stageValid_q;
   end else begin : g_lat1
      assign rdData_d  = rdWord;
      assign rdValid_d = rdAccept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
         dropErr_q <= 1'b0;
      end else begin
         rdValid_q <= rdValid_d;
         if (rdValid_d) begin
            rdData_q <= rdData_d;
         end
         if (busy && (wr_en || rd_en)) begin
            dropErr_q <= 1'b1;
         end
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;
   assign drop_err = dropErr_q;

endmodule

// File: tb/tb_mem_dp_be.sv
// Directed bench for mem_dp_be: instance A uses the default configuration, instance B
// uses 2-cycle reads, write-first collisions and no clear sequencer; both share stimulus.
module tb_mem_dp_be;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rstA, rstB;
   logic          wrEn, rdEn;
   logic [AW-1:0] wrAddr, rdAddr;
   logic [DW-1:0] wrData;
   logic [3:0]    wrBe;
   logic [DW-1:0] rdDataA, rdDataB;
   logic          rdValidA, rdValidB, busyA, busyB, dropErrA, dropErrB;
   int            assertCount = 0;
   int            failCount = 0;
   int            busyCycles;

   always #5 clk = ~clk;

   mem_dp_be #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .WR_FIRST(0), .CLEAR_ON_RESET(1)
   ) dutA (
      .clk(clk), .rst(rstA),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
      .rd_en(rdEn), .rd_addr(rdAddr),
      .rd_data(rdDataA), .rd_valid(rdValidA), .busy(busyA), .drop_err(dropErrA)
   );

   mem_dp_be #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .WR_FIRST(1), .CLEAR_ON_RESET(0)
   ) dutB (
      .clk(clk), .rst(rstB),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
      .rd_en(rdEn), .rd_addr(rdAddr),
      .rd_data(rdDataB), .rd_valid(rdValidB), .busy(busyB), .drop_err(dropErrB)
   );

   // Inputs change 1 time unit after each rising edge, outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
      wrEn   = we;
      wrAddr = wa;
      wrData = wd;
      wrBe   = be;
      rdEn   = re;
      rdAddr = ra;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, '0);
   endtask

   task automatic test_reset();
      rstA = 1'b1;
      rstB = 1'b1;
      idle();
      tick();
      tick();
      assertCount++; if (rdDataA !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rd_data_a: got %h expected %h", rdDataA, 32'h0); end
      assertCount++; if (rdValidA !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rd_valid_a: got %b expected 0", rdValidA); end
      assertCount++; if (busyA !== 1'b1) begin failCount++; $display("[TB] FAIL reset_busy_a: got %b expected 1", busyA); end
      assertCount++; if (dropErrA !== 1'b0) begin failCount++; $display("[TB] FAIL reset_drop_err_a: got %b expected 0", dropErrA); end
      assertCount++; if (busyB !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy_b: got %b expected 0", busyB); end
      assertCount++; if (rdDataB !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rd_data_b: got %h expected %h", rdDataB, 32'h0); end
      rstA = 1'b0;
      rstB = 1'b0;
      busyCycles = 0;
      while (busyA === 1'b1 && busyCycles < 40) begin
         busyCycles++;
         tick();
      end
      assertCount++; if (busyCycles != 16) begin failCount++; $display("[TB] FAIL clear_duration: got %0d cycles expected 16", busyCycles); end
      assertCount++; if (busyA !== 1'b0) begin failCount++; $display("[TB] FAIL clear_done_busy: got %b expected 0", busyA); end
   endtask

   task automatic test_clear_reads();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, AW'(i));
         tick();
         assertCount++; if (rdValidA !== 1'b1) begin failCount++; $display("[TB] FAIL clear_read_valid[%0d]: got %b expected 1", i, rdValidA); end
         assertCount++; if (rdDataA !== 32'h0) begin failCount++; $display("[TB] FAIL clear_read_data[%0d]: got %h expected %h", i, rdDataA, 32'h0); end
      end
      idle();
      tick();
      assertCount++; if (rdValidA !== 1'b0) begin failCount++; $display("[TB] FAIL idle_valid: got %b expected 0", rdValidA); end
   endtask

   task automatic test_byte_enables();
      applyStimulus(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, '0);
      tick();
      applyStimulus(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, '0);
      tick();
      applyStimulus(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'd3);
      tick();
      assertCount++; if (rdDataA !== 32'hAA22CC44) begin failCount++; $display("[TB] FAIL byte_enable_a: got %h expected %h", rdDataA, 32'hAA22CC44); end
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd3);
      tick();
      assertCount++; if (rdDataA !== 32'hAA22CC44) begin failCount++; $display("[TB] FAIL be_zero_noop_a: got %h expected %h", rdDataA, 32'hAA22CC44); end
      assertCount++; if (rdDataB !== 32'hAA22CC44) begin failCount++; $display("[TB] FAIL be_zero_collision_b: got %h expected %h", rdDataB, 32'hAA22CC44); end
      idle();
      tick();
      assertCount++; if (rdDataB !== 32'hAA22CC44) begin failCount++; $display("[TB] FAIL byte_enable_b: got %h expected %h", rdDataB, 32'hAA22CC44); end
      tick();
   endtask

   task automatic test_collision();
      applyStimulus(1'b1, 4'd5, 32'h0, 4'b1111, 1'b0, '0);
      tick();
      applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd5);
      tick();
      assertCount++; if (rdDataA !== 32'h0) begin failCount++; $display("[TB] FAIL collision_old_a: got %h expected %h", rdDataA, 32'h0); end
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd5);
      tick();
      assertCount++; if (rdDataA !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL collision_next_a: got %h expected %h", rdDataA, 32'hDEADBEEF); end
      assertCount++; if (rdValidB !== 1'b1 || rdDataB !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL collision_new_b: got %b/%h expected 1/%h", rdValidB, rdDataB, 32'hDEADBEEF); end
      applyStimulus(1'b1, 4'd5, 32'h55667788, 4'b0011, 1'b1, 4'd5);
      tick();
      assertCount++; if (rdDataA !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL partial_collision_old_a: got %h expected %h", rdDataA, 32'hDEADBEEF); end
      assertCount++; if (rdDataB !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL collision_next_b: got %h expected %h", rdDataB, 32'hDEADBEEF); end
      applyStimulus(1'b1, 4'd6, 32'hCAFEF00D, 4'b1111, 1'b1, 4'd5);
      tick();
      assertCount++; if (rdDataA !== 32'hDEAD7788) begin failCount++; $display("[TB] FAIL other_addr_write_a: got %h expected %h", rdDataA, 32'hDEAD7788); end
      assertCount++; if (rdDataB !== 32'hDEAD7788) begin failCount++; $display("[TB] FAIL partial_merge_b: got %h expected %h", rdDataB, 32'hDEAD7788); end
      idle();
      tick();
      assertCount++; if (rdValidA !== 1'b0) begin failCount++; $display("[TB] FAIL collision_idle_valid_a: got %b expected 0", rdValidA); end
      assertCount++; if (rdValidB !== 1'b1 || rdDataB !== 32'hDEAD7788) begin failCount++; $display("[TB] FAIL other_addr_write_b: got %b/%h expected 1/%h", rdValidB, rdDataB, 32'hDEAD7788); end
      tick();
   endtask

   task automatic test_latency();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, AW'(i), DW'(32'h10 + i), 4'b1111, 1'b0, '0);
         tick();
      end
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd0);
      tick();
      assertCount++; if (rdValidB !== 1'b0) begin failCount++; $display("[TB] FAIL latency2_early_valid: got %b expected 0", rdValidB); end
      assertCount++; if (rdValidA !== 1'b1 || rdDataA !== 32'h10) begin failCount++; $display("[TB] FAIL latency1_first: got %b/%h expected 1/%h", rdValidA, rdDataA, 32'h10); end
      for (int i = 0; i < 4; i++) begin
         if (i < 3) applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, AW'(i + 1));
         else idle();
         tick();
         assertCount++; if (rdValidB !== 1'b1 || rdDataB !== DW'(32'h10 + i)) begin failCount++; $display("[TB] FAIL latency2_pipe[%0d]: got %b/%h expected 1/%h", i, rdValidB, rdDataB, 32'h10 + i); end
      end
      tick();
      assertCount++; if (rdValidB !== 1'b0 || rdDataB !== 32'h13) begin failCount++; $display("[TB] FAIL latency2_hold: got %b/%h expected 0/%h", rdValidB, rdDataB, 32'h13); end
   endtask

   task automatic test_busy_drop();
      rstA = 1'b1;
      tick();
      rstA = 1'b0;
      tick();
      tick();
      tick();
      applyStimulus(1'b1, 4'd2, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'd0);
      tick();
      idle();
      assertCount++; if (dropErrA !== 1'b1) begin failCount++; $display("[TB] FAIL drop_err_set: got %b expected 1", dropErrA); end
      assertCount++; if (rdValidA !== 1'b0) begin failCount++; $display("[TB] FAIL busy_read_ignored: got %b expected 0", rdValidA); end
      assertCount++; if (dropErrB !== 1'b0) begin failCount++; $display("[TB] FAIL drop_err_ready_b: got %b expected 0", dropErrB); end
      tick();
      tick();
      assertCount++; if (dropErrA !== 1'b1 || busyA !== 1'b1) begin failCount++; $display("[TB] FAIL drop_err_sticky: got %b/%b expected 1/1", dropErrA, busyA); end
      rstA = 1'b1;
      tick();
      assertCount++; if (dropErrA !== 1'b0 || busyA !== 1'b1) begin failCount++; $display("[TB] FAIL midclear_reset: got %b/%b expected 0/1", dropErrA, busyA); end
      assertCount++; if (rdDataA !== 32'h0 || rdValidA !== 1'b0) begin failCount++; $display("[TB] FAIL midclear_reset_rd: got %h/%b expected %h/0", rdDataA, rdValidA, 32'h0); end
      rstA = 1'b0;
      busyCycles = 0;
      while (busyA === 1'b1 && busyCycles < 40) begin
         busyCycles++;
         tick();
      end
      assertCount++; if (busyCycles != 16) begin failCount++; $display("[TB] FAIL restart_clear_duration: got %0d cycles expected 16", busyCycles); end
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd2);
      tick();
      idle();
      assertCount++; if (rdValidA !== 1'b1 || rdDataA !== 32'h0) begin failCount++; $display("[TB] FAIL dropped_write_addr2: got %b/%h expected 1/%h", rdValidA, rdDataA, 32'h0); end
      tick();
      tick();
   endtask

   task automatic test_no_clear();
      applyStimulus(1'b1, 4'd7, 32'h12345678, 4'b1111, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd7);
      tick();
      idle();
      tick();
      assertCount++; if (rdValidB !== 1'b1 || rdDataB !== 32'h12345678) begin failCount++; $display("[TB] FAIL noclear_pre_read: got %b/%h expected 1/%h", rdValidB, rdDataB, 32'h12345678); end
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd7);
      tick();
      idle();
      rstB = 1'b1;
      #2;
      assertCount++; if (busyB !== 1'b0 || rdDataB !== 32'h0 || rdValidB !== 1'b0) begin failCount++; $display("[TB] FAIL noclear_reset: got busy %b data %h valid %b expected 0/%h/0", busyB, rdDataB, rdValidB, 32'h0); end
      rstB = 1'b0;
      tick();
      assertCount++; if (rdValidB !== 1'b0 || busyB !== 1'b0) begin failCount++; $display("[TB] FAIL noclear_pipe_flush: got valid %b busy %b expected 0/0", rdValidB, busyB); end
      applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 4'd7);
      tick();
      idle();
      assertCount++; if (rdValidA !== 1'b1 || rdDataA !== 32'h12345678) begin failCount++; $display("[TB] FAIL noclear_read_a: got %b/%h expected 1/%h", rdValidA, rdDataA, 32'h12345678); end
      tick();
      assertCount++; if (rdValidB !== 1'b1 || rdDataB !== 32'h12345678 || busyB !== 1'b0) begin failCount++; $display("[TB] FAIL noclear_retained: got %b/%h busy %b expected 1/%h/0", rdValidB, rdDataB, busyB, 32'h12345678); end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_clear_reads();
      test_byte_enables();
      test_collision();
      test_latency();
      test_busy_drop();
      test_no_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
